fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Boot/run controller for the instruction-fetch stage. Streams a program from a host
//  into instruction memory via the fetch stage's init port, holds PC/fetch in reset
//  during load, releases it to run, then stops the core on a halt word or cycle budget.
//  Sits between host loader and fetch stage; drives its init/write/reset inputs.
// PARAMETERS
//  ADDR_W      12            init_address width (word index into instruction memory)
//  DEPTH       4096          memory capacity in words; load beyond is an error
//  HALT_WORD   32'h0000000C  fetched instruction value that ends the run (syscall)
//  MAX_CYCLES  1000000       RUN cycle budget before timeout error
// PORTS
//  clk               in   1       clock, all state on rising edge
//  reset_n           in   1       one clock; reset is asynchronous and active-low
//  start             in   1       begin load; sampled only in IDLE or HALT
//  host_valid        in   1       host program word valid
//  host_ready        out  1       controller accepts word (valid&ready = beat)
//  host_data         in   32      program word
//  host_last         in   1       marks final word of program
//  instruction       in   32      word currently fetched by fetch stage
//  init_mode         out  1       selects init write path of instruction memory
//  write_enable      out  1       instruction-memory write strobe
//  init_address      out  ADDR_W  write word address
//  init_instruction  out  32      write data
//  core_reset        out  1       active-high reset to PC/fetch (PC -> 32'h00400000)
//  running           out  1       high in RUN
//  done              out  1       high in HALT
//  error             out  1       sticky until next start: overflow or timeout
//  words_loaded      out  ADDR_W+1 beats accepted this load
//  cycle_count       out  32      RUN cycles elapsed, frozen in HALT
// BEHAVIOUR
//  Reset: state IDLE; core_reset=1; all other outputs 0; counters 0.
//  States: IDLE, LOAD, FLUSH, BOOT, RUN, HALT. All outputs registered.
//  IDLE: host_ready=0, init_mode=0, core_reset=1. start -> LOAD.
//  LOAD: init_mode=1, host_ready=1. Beat -> next cycle write_enable=1 for exactly 1 cycle,
//   init_address=words_loaded (pre-increment), init_instruction=host_data; words_loaded++.
//   Beat with host_last -> FLUSH. Beat with words_loaded==DEPTH -> no write, error=1, HALT.
//   Gaps in host_valid: no write, stay in LOAD.
//  FLUSH (1 cycle): host_ready=0, init_mode=1, last write completes -> BOOT.
//  BOOT (1 cycle): init_mode=0, core_reset=1 -> RUN.
//  RUN: core_reset=0, running=1, cycle_count++ each cycle. From 2nd RUN cycle on,
//   instruction==HALT_WORD -> HALT (error=0). cycle_count==MAX_CYCLES-1 -> HALT, error=1.
//   Halt word and timeout same cycle: HALT with error=0 (halt wins).
//  HALT: core_reset=1, done=1, counters frozen. start -> LOAD, clears words_loaded,
//   cycle_count, error, done. start outside IDLE/HALT ignored.
//  cycle_count saturates at 2^32-1; words_loaded never exceeds DEPTH.
//  reset_n low mid-load/run: immediate return to reset values; memory contents
//   already written are left as-is, not re-verified.
// STRUCTURE
//  Package fetch_seq_pkg: state encoding, PC_RESET_VEC 32'h00400000, HALT_WORD default.
//  One sub-module: sat_counter (width param, clear/enable, saturate) for words_loaded
//  and cycle_count. FSM + write registers in this module.
// TESTING
//  3-word load {A,B,C}, last on C -> writes addr 0,1,2 data A,B,C, FLUSH, BOOT, RUN.
//  host_valid toggled every other cycle -> writes only on beats, addresses contiguous.
//  DEPTH=4, 5 beats no last -> 4 writes, error=1, done=1, no 5th write_enable.
//  Program with HALT_WORD at word 3 -> done=1, core_reset=1, cycle_count frozen.
//  MAX_CYCLES=16, no halt word -> HALT at cycle_count==15, error=1; start clears error.
//  reset_n low during LOAD after 2 beats -> outputs reset next edge-independent, IDLE.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch boot/run controller.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } state_t;

  localparam logic [31:0] PC_RESET_VEC      = 32'h0040_0000;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'h0000_000C;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Host program-stream handshake: one word per valid&ready beat, last marks the end.
interface fetch_sequencer_if;

  logic        host_valid;
  logic        host_ready;
  logic [31:0] host_data;
  logic        host_last;

  modport master (output host_valid, host_data, host_last, input host_ready);
  modport slave  (input host_valid, host_data, host_last, output host_ready);

endinterface

// File: rtl/fetch_sequencer_sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Boot/run controller: streams a host program into instruction memory, boots the
// core, and stops it on a halt word or when the RUN cycle budget runs out.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DEPTH      = 4096,
  parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT,
  parameter int unsigned MAX_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  fetch_sequencer_if.slave  host,
  input  logic [31:0]       instruction,
  output logic              init_mode,
  output logic              write_enable,
  output logic [ADDR_W-1:0] init_address,
  output logic [31:0]       init_instruction,
  output logic              core_reset,
  output logic              running,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded,
  output logic [31:0]       cycle_count
);

  state_t r_state, w_next;

  logic              w_start, w_beat, w_write, w_overflow, w_timeout, w_run_en;
  logic              r_host_ready, r_init_mode, r_write_enable, r_core_reset;
  logic              r_running, r_done, r_error;
  logic [ADDR_W-1:0] r_init_address;
  logic [31:0]       r_init_instruction;

  always_comb begin
    w_next     = r_state;
    w_start    = start && ((r_state == ST_IDLE) || (r_state == ST_HALT));
    w_beat     = 1'b0;
    w_write    = 1'b0;
    w_overflow = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALT: if (w_start) w_next = ST_LOAD;
      ST_LOAD: begin
        w_beat = host.host_valid && r_host_ready;
        if (w_beat) begin
          if (words_loaded == (ADDR_W+1)'(DEPTH)) begin
            w_overflow = 1'b1;
            w_next     = ST_HALT;
          end else begin
            w_write = 1'b1;
            if (host.host_last) w_next = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: w_next = ST_BOOT;
      ST_BOOT:  w_next = ST_RUN;
      // First RUN cycle still shows a stale fetch, so the halt word is ignored there.
      ST_RUN: begin
        if ((cycle_count != '0) && (instruction == HALT_WORD)) begin
          w_next = ST_HALT;
        end else if (cycle_count == 32'(MAX_CYCLES - 1)) begin
          w_timeout = 1'b1;
          w_next    = ST_HALT;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Every RUN cycle counts, including the one that hands over to HALT.
  assign w_run_en = (r_state == ST_RUN);

  sat_counter #(.WIDTH(ADDR_W + 1)) u_words_loaded (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (w_start),
    .i_enable (w_write),
    .o_count  (words_loaded)
  );

  sat_counter #(.WIDTH(32)) u_cycle_count (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (w_start),
    .i_enable (w_run_en),
    .o_count  (cycle_count)
  );

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state            <= ST_IDLE;
      r_host_ready       <= 1'b0;
      r_init_mode        <= 1'b0;
      r_write_enable     <= 1'b0;
      r_init_address     <= '0;
      r_init_instruction <= '0;
      r_core_reset       <= 1'b1;
      r_running          <= 1'b0;
      r_done             <= 1'b0;
      r_error            <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_host_ready   <= (w_next == ST_LOAD);
      r_init_mode    <= (w_next == ST_LOAD) || (w_next == ST_FLUSH);
      r_write_enable <= w_write;
      if (w_write) begin
        r_init_address     <= words_loaded[ADDR_W-1:0];
        r_init_instruction <= host.host_data;
      end
      r_core_reset <= (w_next != ST_RUN);
      r_running    <= (w_next == ST_RUN);
      r_done       <= (w_next == ST_HALT);
      if (w_start) begin
        r_error <= 1'b0;
      end else if (w_overflow || w_timeout) begin
        r_error <= 1'b1;
      end
    end
  end

  assign host.host_ready  = r_host_ready;
  assign init_mode        = r_init_mode;
  assign write_enable     = r_write_enable;
  assign init_address     = r_init_address;
  assign init_instruction = r_init_instruction;
  assign core_reset       = r_core_reset;
  assign running          = r_running;
  assign done             = r_done;
  assign error            = r_error;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a small fetch-stage/memory model drives the instruction
// input; table vectors, hand sequences and random programs are checked against a model.
module tb_fetch_sequencer;
  import fetch_seq_pkg::*;

  localparam int unsigned TB_ADDR_W = 2;
  localparam int unsigned TB_DEPTH  = 4;
  localparam int unsigned TB_MAX    = 16;
  localparam logic [31:0] HALT      = HALT_WORD_DEFAULT;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef struct {
    logic [4:0][31:0] w;
    int unsigned      len;
    bit               last;
    bit               gaps;
    bit               exp_err;
    int unsigned      exp_cyc;
    int unsigned      exp_words;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 reset_n, start;
  logic [31:0]          instruction;
  logic                 init_mode, write_enable, core_reset, running, done, error;
  logic [TB_ADDR_W-1:0] init_address;
  logic [31:0]          init_instruction;
  logic [TB_ADDR_W:0]   words_loaded;
  logic [31:0]          cycle_count;

  fetch_sequencer_if hif ();

  fetch_sequencer #(
    .ADDR_W     (TB_ADDR_W),
    .DEPTH      (TB_DEPTH),
    .HALT_WORD  (HALT),
    .MAX_CYCLES (TB_MAX)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .host             (hif.slave),
    .instruction      (instruction),
    .init_mode        (init_mode),
    .write_enable     (write_enable),
    .init_address     (init_address),
    .init_instruction (init_instruction),
    .core_reset       (core_reset),
    .running          (running),
    .done             (done),
    .error            (error),
    .words_loaded     (words_loaded),
    .cycle_count      (cycle_count)
  );

  always #5 clk = ~clk;

  // Fetch stage + instruction memory: PC held at reset vector, word index wraps.
  logic [31:0] imem [TB_DEPTH];
  logic [31:0] pc = PC_RESET_VEC;
  logic [31:0] pc_off;
  logic        clr_mem, force_halt;

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < int'(TB_DEPTH); i++) imem[i] <= NOP;
    end else if (init_mode && write_enable) begin
      imem[init_address] <= init_instruction;
    end
    pc <= core_reset ? PC_RESET_VEC : pc + 32'd4;
  end

  always_comb begin
    pc_off      = pc - PC_RESET_VEC;
    instruction = force_halt ? HALT : imem[pc_off[3:2]];
  end

  logic [33:0] got_q [$];
  always @(negedge clk) begin
    if (write_enable === 1'b1) got_q.push_back({init_address, init_instruction});
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [TB_DEPTH];
  logic [33:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    @(negedge clk);
    clr_mem = 1'b1;
    @(negedge clk);
    clr_mem = 1'b0;
    for (int i = 0; i < int'(TB_DEPTH); i++) ref_mem[i] = NOP;
  endtask

  function automatic vec_t mk(input logic [31:0] a, b, c, d, e, input int unsigned len,
                              input bit last, gaps, err, input int unsigned cyc, words);
    vec_t v;
    v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d; v.w[4] = e;
    v.len = len; v.last = last; v.gaps = gaps;
    v.exp_err = err; v.exp_cyc = cyc; v.exp_words = words;
    return v;
  endfunction

  // Reference: first min(len,DEPTH) words land at 0..; the run halts on the first
  // halt word fetched from RUN cycle 2 on (cycle k fetches word (k-1) mod DEPTH).
  task automatic predict(input vec_t v, output bit err, output int unsigned cyc,
                         output int unsigned words);
    int unsigned nw;
    nw = (v.len > TB_DEPTH) ? TB_DEPTH : v.len;
    exp_q.delete();
    for (int unsigned i = 0; i < nw; i++) begin
      exp_q.push_back({TB_ADDR_W'(i), v.w[i]});
      ref_mem[i] = v.w[i];
    end
    words = nw;
    if (v.len > TB_DEPTH) begin
      err = 1'b1;
      cyc = 0;
    end else begin
      err = 1'b1;
      cyc = TB_MAX;
      for (int unsigned k = 2; k <= TB_MAX; k++) begin
        if (ref_mem[(k - 1) % TB_DEPTH] == HALT) begin
          err = 1'b0;
          cyc = k;
          break;
        end
      end
    end
  endtask

  task automatic load(input vec_t v);
    int t;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int unsigned i = 0; i < v.len; i++) begin
      if (v.gaps) begin
        hif.host_valid = 1'b0;
        @(negedge clk);
      end
      hif.host_valid = 1'b1;
      hif.host_data  = v.w[i];
      hif.host_last  = v.last && (i == v.len - 1);
      t = 0;
      while (!hif.host_ready && t < 8) begin
        @(negedge clk);
        t++;
      end
      if (t >= 8) check("ready_timeout", 64'(t), 64'd0);
      @(negedge clk);
    end
    hif.host_valid = 1'b0;
    hif.host_last  = 1'b0;
  endtask

  task automatic wait_done(input bit poke_start);
    int t = 0;
    while (!done && t < 80) begin
      start = (poke_start && running) ? 1'($urandom_range(1, 0)) : 1'b0;
      @(negedge clk);
      t++;
    end
    start = 1'b0;
  endtask

  task automatic run_vector(input vec_t v, input string tag, input bit use_table);
    bit          m_err;
    int unsigned m_cyc, m_words, base;
    predict(v, m_err, m_cyc, m_words);
    if (use_table) begin
      m_err = v.exp_err; m_cyc = v.exp_cyc; m_words = v.exp_words;
    end
    base = got_q.size();
    load(v);
    wait_done(!use_table);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " error"}, 64'(error), 64'(m_err));
    check({tag, " cycle_count"}, 64'(cycle_count), 64'(m_cyc));
    check({tag, " words_loaded"}, 64'(words_loaded), 64'(m_words));
    check({tag, " core_reset"}, 64'(core_reset), 64'd1);
    check({tag, " writes"}, 64'(got_q.size() - base), 64'(exp_q.size()));
    for (int unsigned i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_q.size()) check({tag, " write"}, 64'(got_q[base + i]), 64'(exp_q[i]));
    end
  endtask

  vec_t tbl [7];
  vec_t v;

  initial begin
    reset_n = 1'b0; start = 1'b0; clr_mem = 1'b1; force_halt = 1'b0;
    hif.host_valid = 1'b0; hif.host_data = '0; hif.host_last = 1'b0;
    for (int i = 0; i < int'(TB_DEPTH); i++) ref_mem[i] = NOP;
    repeat (3) @(negedge clk);
    check("rst core_reset", 64'(core_reset), 64'd1);
    check("rst host_ready", 64'(hif.host_ready), 64'd0);
    check("rst init_mode", 64'(init_mode), 64'd0);
    check("rst write_enable", 64'(write_enable), 64'd0);
    check("rst running/done/error", 64'({running, done, error}), 64'd0);
    check("rst counters", 64'({words_loaded, cycle_count}), 64'd0);
    reset_n = 1'b1;
    clr_mem = 1'b0;

    tbl[0] = mk(32'h11, 32'h22, 32'h33, 0, 0, 3, 1, 0, 1, 16, 3);
    tbl[1] = mk(32'h11, 32'h22, 32'h33, HALT, 0, 4, 1, 1, 0, 4, 4);
    tbl[2] = mk(HALT, 32'h55, 0, 0, 0, 2, 1, 0, 0, 5, 2);
    tbl[3] = mk(32'h77, HALT, 0, 0, 0, 2, 1, 1, 0, 2, 2);
    tbl[4] = mk(32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 5, 0, 0, 1, 0, 4);
    tbl[5] = mk(32'h1, 32'h2, 32'h3, 32'h4, 0, 4, 1, 1, 1, 16, 4);
    tbl[6] = mk(HALT, 0, 0, 0, 0, 1, 1, 0, 0, 5, 1);
    for (int i = 0; i < 7; i++) begin
      clear_mem();
      run_vector(tbl[i], $sformatf("tbl%0d", i), 1'b1);
    end

    // FLUSH / BOOT / RUN entry timing after a 3-word load.
    clear_mem();
    load(mk(32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 0, 0, 3, 1, 0, 0, 0, 0));
    check("flush we", 64'(write_enable), 64'd1);
    check("flush addr/data", 64'({init_address, init_instruction}), 64'({2'd2, 32'hC0C0_0003}));
    check("flush ready/mode/cr", 64'({hif.host_ready, init_mode, core_reset}), 64'b011);
    @(negedge clk);
    check("boot mode/cr/run/we", 64'({init_mode, core_reset, running, write_enable}), 64'b0100);
    @(negedge clk);
    check("run cr/run/cnt", 64'({core_reset, running, cycle_count}), 64'({2'b01, 32'd0}));
    wait_done(1'b0);
    check("A timeout error", 64'({done, error, cycle_count}), 64'({2'b11, 32'd16}));

    // start from HALT clears sticky state and enters LOAD.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("restart err/done", 64'({error, done}), 64'd0);
    check("restart counters", 64'({words_loaded, cycle_count}), 64'd0);
    check("restart ready/mode", 64'({hif.host_ready, init_mode}), 64'b11);

    // Two beats, then asynchronous reset mid-load.
    hif.host_valid = 1'b1; hif.host_data = 32'h0101_0101;
    @(negedge clk); hif.host_data = 32'h0202_0202;
    @(negedge clk); hif.host_valid = 1'b0;
    check("midload words", 64'(words_loaded), 64'd2);
    #2 reset_n = 1'b0;
    #1;
    check("async rst outputs", 64'({core_reset, init_mode, hif.host_ready, write_enable}), 64'b1000);
    check("async rst status", 64'({running, done, error, words_loaded}), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    check("idle after rst", 64'({hif.host_ready, init_mode, core_reset}), 64'b001);

    // Halt word on the very cycle the budget expires: halt wins.
    clear_mem();
    load(mk(32'h1, 32'h2, 32'h3, 32'h4, 0, 4, 1, 0, 0, 0, 0));
    for (int t = 0; t < 60 && !done; t++) begin
      if (running && cycle_count == 32'd15) force_halt = 1'b1;
      @(negedge clk);
    end
    force_halt = 1'b0;
    check("tie done/error", 64'({done, error}), 64'b10);
    check("tie cycle_count", 64'(cycle_count), 64'd16);

    // Random programs, memory carried over between runs.
    clear_mem();
    for (int n = 0; n < 30; n++) begin
      v = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      if ($urandom_range(5, 0) == 0) begin
        v.len = 5; v.last = 1'b0;
      end else begin
        v.len = $urandom_range(TB_DEPTH, 1);
      end
      v.gaps = 1'($urandom_range(1, 0));
      for (int i = 0; i < 5; i++) v.w[i] = ($urandom_range(4, 0) == 0) ? HALT : $urandom;
      run_vector(v, $sformatf("rnd%0d", n), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
